fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised next-generation instruction fetch unit with a prefetch queue between the I-cache port and decode.
- Keeps at most one cache request outstanding and keeps fetching sequentially while decode stalls, until the queue is full.
- On jal or branch redirect: flushes the queue and discards any stale in-flight response, using an explicit drain state.
- Sits between the I-cache and the decode stage and drives decode's pc/instruction pair.

Parameters:
- XLEN, 32, width of PC and addresses.
- DEPTH, 4, prefetch queue entries (power of two, ≥2).
- RESET_PC, 0, first fetch address after reset.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cache_ack  in  1  response valid for the outstanding request (may arrive in the same cycle as the request: hit).
- inst  in  32  instruction returned with cache_ack.
- addr_ready  out  1  request valid, held until cache_ack.
- addr  out  XLEN  request address, stable while addr_ready is high.
- stall  in  1  decode cannot accept; hold outputs.
- jal  in  1  jump redirect.
- branch  in  1  taken-branch redirect.
- j_target  in  XLEN  jal target.
- b_target  in  XLEN  branch target.
- final_pc  out  XLEN  pc to decode (registered).
- final_inst  out  32  instruction to decode (registered).
- q_count  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, queue empty, q_count=0.
  - final_pc=RESET_PC-4, final_inst=NOP_INST.
  - addr_ready forced 0 while rst_n is low.
  - The cache shares this reset, so no pre-reset response survives.
- Redirect:
  - redirect = jal|branch. When both are high, jal wins (target j_target), otherwise b_target.
  - Redirect beats stall.
- State IDLE (no request pending):
  - If redirect: fetch_pc←target. Flush the queue. No request is issued this cycle.
  - Else if q_count < DEPTH: addr_ready=1, addr=fetch_pc.
    - With cache_ack in the same cycle: push {fetch_pc,inst}, fetch_pc+=4, stay in IDLE.
    - Without it: go to WAIT.
- State WAIT (live request pending; addr=fetch_pc, addr_ready=1):
  - cache_ack and no redirect: push {fetch_pc,inst}, fetch_pc+=4, go to IDLE.
  - redirect with cache_ack: discard inst, fetch_pc←target, flush, go to IDLE.
  - redirect without cache_ack: fetch_pc←target, flush, go to DRAIN.
- State DRAIN (stale request pending):
  - addr_ready=1, addr = latched stale address (held in a separate req_addr register).
  - A further redirect updates fetch_pc and the later one wins.
  - cache_ack: discard the response, go to IDLE.
- Push/space rule:
  - A request is issued only when q_count < DEPTH, so a push never overflows.
  - A pop in the same cycle as a push is legal. Occupancy is then unchanged.
- Output register, evaluated at each edge in this priority order:
  1. redirect: final_inst←NOP_INST, final_pc held.
  2. stall: hold both outputs.
  3. Queue non-empty: pop the head into final_pc/final_inst.
  4. Queue empty and a live ack this cycle (IDLE hit or WAIT ack): bypass {fetch_pc,inst} straight to the outputs with no push.
  5. Otherwise: final_inst←NOP_INST, final_pc held.
- Latency and throughput:
  - Hit with an empty queue: the instruction appears at decode 1 cycle after the request cycle.
  - Sustained throughput is 1 instruction per cycle on hits.
- Ordering: strict program order. A discarded response never reaches the queue or the outputs.
- Width: fetch_pc+4 wraps modulo 2^XLEN. Targets are used as given, with no alignment check.

Decomposition:
- fetch_pkg holds:
  - the fetch_state_t enum {IDLE, WAIT, DRAIN};
  - NOP_INST_DEFAULT;
  - the queue entry struct {pc, inst}.
- Sub-module fetch_fifo:
  - synchronous FIFO with parameters WIDTH and DEPTH;
  - push, pop, flush, count, head;
  - flush has priority over push.

Test Plan:
- Always-hit cache, no stall: after reset, addr=0,4,8,… on consecutive cycles; final_pc=0,4,8 on consecutive cycles starting at cycle 1; q_count stays 0.
- Always-hit cache, stall held 6 cycles: q_count rises to 4, then addr_ready=0 and outputs hold. Release stall: final_pc steps through the queued pcs in order, then continues with no gap.
- 3-cycle miss at addr 0x8, jal=1 with j_target=0x100 in the miss's first cycle:
  - state goes to DRAIN and the 0x8 response is discarded;
  - the next request has addr=0x100;
  - final_inst=NOP_INST until the 0x100 ack, then final_pc=0x100.
- jal=1 and branch=1 in the same cycle, j_target=0x200, b_target=0x300: the next request is 0x200; no fetch from 0x300 occurs.
- Queue full (q_count=4), stall=1, branch=1 with b_target=0x40: q_count→0 and final_inst=NOP_INST on the next edge; the next request is 0x40.
- rst_n pulsed low in the middle of a WAIT miss: addr_ready drops immediately; final_pc=RESET_PC-4, final_inst=NOP_INST; after release the first request is addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // Queue entry layout at the default 32-bit PC; the top builds the same {pc, inst} layout at its own XLEN.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Cache request/response, redirect and decode-side signals of the fetch unit.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            cache_ack;
    logic [31:0]     inst;
    logic            addr_ready;
    logic [XLEN-1:0] addr;
    logic            stall;
    logic            jal;
    logic            branch;
    logic [XLEN-1:0] j_target;
    logic [XLEN-1:0] b_target;
    logic [XLEN-1:0] final_pc;
    logic [31:0]     final_inst;
    logic [CW-1:0]   q_count;

    modport master (
        input  cache_ack, inst, stall, jal, branch, j_target, b_target,
        output addr_ready, addr, final_pc, final_inst, q_count
    );

    modport slave (
        output cache_ack, inst, stall, jal, branch, j_target, b_target,
        input  addr_ready, addr, final_pc, final_inst, q_count
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with occupancy count; flush wins over push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !flush_i;
    assign pop_ok  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding I-cache request, prefetch queue, registered decode outputs.
//   state | meaning
//   IDLE  | no request pending; issue at fetch_pc when the queue has space
//   WAIT  | live request at fetch_pc pending
//   DRAIN | stale request at req_addr pending; its response is dropped
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = NOP_INST_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_queue_if.master  fq
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] final_pc_q, final_pc_d;
    logic [31:0]     final_inst_q, final_inst_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   count;
    logic            empty, has_space;
    logic            addr_ready, live_ack, push, pop;
    entry_t          head, push_entry;

    assign redirect  = fq.jal || fq.branch;
    assign target    = fq.jal ? fq.j_target : fq.b_target;
    assign empty     = (count == '0);
    assign has_space = (count < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            final_pc_q   <= RESET_PC - XLEN'(4);
            final_inst_q <= NOP_INST;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            final_pc_q   <= final_pc_d;
            final_inst_q <= final_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end else if (has_space) begin
                    if (fq.cache_ack) fetch_pc_d = fetch_pc_q + XLEN'(4);
                    else              state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = fq.cache_ack ? IDLE : DRAIN;
                end else if (fq.cache_ack) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (redirect)     fetch_pc_d = target;
                if (fq.cache_ack) state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_ready   = 1'b0;
        final_pc_d   = final_pc_q;
        final_inst_d = final_inst_q;
        unique case (state_q)
            IDLE:        addr_ready = !redirect && has_space;
            WAIT, DRAIN: addr_ready = 1'b1;
            default:     addr_ready = 1'b0;
        endcase

        live_ack = fq.cache_ack && !redirect &&
                   (((state_q == IDLE) && has_space) || (state_q == WAIT));
        pop  = !redirect && !fq.stall && !empty;
        // An ack only skips the queue when decode is taking it this cycle and nothing is older.
        push = live_ack && (fq.stall || !empty);

        if (redirect) begin
            final_inst_d = NOP_INST;
        end else if (fq.stall) begin
            final_inst_d = final_inst_q;
        end else if (!empty) begin
            final_pc_d   = head.pc;
            final_inst_d = head.inst;
        end else if (live_ack) begin
            final_pc_d   = fetch_pc_q;
            final_inst_d = fq.inst;
        end else begin
            final_inst_d = NOP_INST;
        end
    end

    assign push_entry = '{pc: fetch_pc_q, inst: fq.inst};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .count_o (count),
        .head_o  (head)
    );

    assign fq.addr_ready = addr_ready && rst_n;
    assign fq.addr       = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
    assign fq.final_pc   = final_pc_q;
    assign fq.final_inst = final_inst_q;
    assign fq.q_count    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a simple hit/miss I-cache model.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    logic hit_mode;
    logic ack_force;
    int   n_chk;
    int   n_bad;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .NOP_INST (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fq    (bus.master)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hABC0_0000;
    endfunction

    assign bus.cache_ack = ack_force | (hit_mode & bus.addr_ready);
    assign bus.inst      = inst_of(bus.addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_chk        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        hit_mode     = 1'b1;
        ack_force    = 1'b0;
        bus.stall    = 1'b0;
        bus.jal      = 1'b0;
        bus.branch   = 1'b0;
        bus.j_target = '0;
        bus.b_target = '0;

        repeat (2) tick();
        check("rst_ready", 64'(bus.addr_ready), 64'd0);
        check("rst_pc",    64'(bus.final_pc),   64'hFFFF_FFFC);
        check("rst_inst",  64'(bus.final_inst), 64'(NOP));
        check("rst_cnt",   64'(bus.q_count),    64'd0);
        rst_n = 1'b1;
        #1;

        // always-hit streaming
        for (int k = 0; k < 5; k++) begin
            check("seq_addr",  64'(bus.addr),       64'(4 * k));
            check("seq_ready", 64'(bus.addr_ready), 64'd1);
            check("seq_cnt",   64'(bus.q_count),    64'd0);
            if (k > 0) begin
                check("seq_pc",   64'(bus.final_pc),   64'(4 * (k - 1)));
                check("seq_inst", 64'(bus.final_inst), 64'(inst_of(32'(4 * (k - 1)))));
            end
            tick();
        end
        check("pre_stall_pc", 64'(bus.final_pc), 64'd16);

        // stall 6 cycles: queue fills to 4 then requests stop
        bus.stall = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("stall_cnt", 64'(bus.q_count),  64'((e < 4) ? e : 4));
            check("stall_pc",  64'(bus.final_pc), 64'd16);
        end
        check("full_ready", 64'(bus.addr_ready), 64'd0);
        bus.stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drain_pc",   64'(bus.final_pc),   64'(20 + 4 * i));
            check("drain_inst", 64'(bus.final_inst), 64'(inst_of(32'(20 + 4 * i))));
            if (i < 2) check("drain_cnt", 64'(bus.q_count), 64'd3);
        end

        // full queue + stall + branch
        bus.stall = 1'b1;
        tick();
        check("full_cnt",    64'(bus.q_count),    64'd4);
        check("full_pc",     64'(bus.final_pc),   64'd48);
        check("full_ready2", 64'(bus.addr_ready), 64'd0);
        bus.branch   = 1'b1;
        bus.b_target = 32'h40;
        #1;
        check("br_ready", 64'(bus.addr_ready), 64'd0);
        tick();
        check("br_cnt",  64'(bus.q_count),    64'd0);
        check("br_inst", 64'(bus.final_inst), 64'(NOP));
        check("br_pc",   64'(bus.final_pc),   64'd48);
        bus.branch = 1'b0;
        bus.stall  = 1'b0;
        #1;
        check("br_addr",   64'(bus.addr),       64'h40);
        check("br_ready2", 64'(bus.addr_ready), 64'd1);
        tick();
        check("br_hit_pc",   64'(bus.final_pc),   64'h40);
        check("br_hit_inst", 64'(bus.final_inst), 64'(inst_of(32'h40)));

        // miss at 0x8 redirected to 0x100 while waiting
        bus.jal      = 1'b1;
        bus.j_target = 32'h8;
        hit_mode     = 1'b0;
        tick();
        bus.jal = 1'b0;
        #1;
        check("miss_addr",  64'(bus.addr),       64'h8);
        check("miss_ready", 64'(bus.addr_ready), 64'd1);
        tick();
        check("wait_addr", 64'(bus.addr),       64'h8);
        check("wait_inst", 64'(bus.final_inst), 64'(NOP));
        bus.jal      = 1'b1;
        bus.j_target = 32'h100;
        tick();
        bus.jal   = 1'b0;
        ack_force = 1'b1;
        #1;
        check("drain_addr",  64'(bus.addr),       64'h8);
        check("drain_ready", 64'(bus.addr_ready), 64'd1);
        check("drain_nop",   64'(bus.final_inst), 64'(NOP));
        tick();
        ack_force = 1'b0;
        hit_mode  = 1'b1;
        #1;
        check("post_drain_addr", 64'(bus.addr),       64'h100);
        check("post_drain_nop",  64'(bus.final_inst), 64'(NOP));
        check("post_drain_cnt",  64'(bus.q_count),    64'd0);
        tick();
        check("j100_pc",   64'(bus.final_pc),   64'h100);
        check("j100_inst", 64'(bus.final_inst), 64'(inst_of(32'h100)));

        // jal and branch together: jal wins
        bus.jal      = 1'b1;
        bus.branch   = 1'b1;
        bus.j_target = 32'h200;
        bus.b_target = 32'h300;
        #1;
        check("both_ready", 64'(bus.addr_ready), 64'd0);
        tick();
        bus.jal    = 1'b0;
        bus.branch = 1'b0;
        #1;
        check("both_addr", 64'(bus.addr),       64'h200);
        check("both_nop",  64'(bus.final_inst), 64'(NOP));
        check("both_hold", 64'(bus.final_pc),   64'h100);
        tick();
        check("both_pc",    64'(bus.final_pc), 64'h200);
        check("both_addr2", 64'(bus.addr),     64'h204);
        tick();
        check("both_pc2", 64'(bus.final_pc), 64'h204);

        // reset in the middle of a WAIT miss
        bus.jal      = 1'b1;
        bus.j_target = 32'h500;
        hit_mode     = 1'b0;
        tick();
        bus.jal = 1'b0;
        #1;
        check("r_miss_addr", 64'(bus.addr), 64'h500);
        tick();
        check("r_wait_ready", 64'(bus.addr_ready), 64'd1);
        check("r_wait_addr",  64'(bus.addr),       64'h500);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.addr_ready), 64'd0);
        check("mid_rst_pc",    64'(bus.final_pc),   64'hFFFF_FFFC);
        check("mid_rst_inst",  64'(bus.final_inst), 64'(NOP));
        check("mid_rst_cnt",   64'(bus.q_count),    64'd0);
        hit_mode = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_addr",  64'(bus.addr),       64'h0);
        check("rel_ready", 64'(bus.addr_ready), 64'd1);
        tick();
        check("rel_pc",   64'(bus.final_pc),   64'h0);
        check("rel_inst", 64'(bus.final_inst), 64'(inst_of(32'h0)));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
